// File: rtl/dmem_ctrl.sv
// Two-port load/store controller for a word-wide data memory: round-robin arbitration,
// sub-word loads with sign/zero extension, and read-modify-write for byte/half stores.
module dmem_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [1:0]        p0_size,
    input  logic              p0_sign,
    input  logic [31:0]       p0_wdata,
    output logic              p0_done,
    output logic              p0_err,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [1:0]        p1_size,
    input  logic              p1_sign,
    input  logic [31:0]       p1_wdata,
    output logic              p1_done,
    output logic              p1_err,
    output logic [31:0]       p1_rdata,
    output logic              mem_ena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_data_bit,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);
    // Handshake: a port holds pN_req (with stable fields until grant) and gets exactly one
    // pN_done pulse per request; pN_err/pN_rdata are meaningful only while pN_done is high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_ILL  = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;        // port preferred on the next contested grant
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] res_q, res_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] hold0_q, hold0_d;
    logic [31:0] hold1_q, hold1_d;

    logic        gnt_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_sign;
    logic [31:0] sel_wdata;
    logic        sel_bad;

    always_comb begin
        gnt_port  = (p0_req && p1_req) ? rr_q : p1_req;
        sel_we    = gnt_port ? p1_we    : p0_we;
        sel_addr  = gnt_port ? p1_addr  : p0_addr;
        sel_size  = gnt_port ? p1_size  : p0_size;
        sel_sign  = gnt_port ? p1_sign  : p0_sign;
        sel_wdata = gnt_port ? p1_wdata : p0_wdata;
        sel_bad   = (sel_size == SZ_ILL)
                 || ((sel_size == SZ_HALF) && sel_addr[0])
                 || ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00))
                 || (sel_addr[31:ADDR_W+2] != '0);
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] merged;

    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_BYTE: ld_val = {{24{sign_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_val = {{16{sign_q & ld_half[15]}}, ld_half};
            default: ld_val = mem_rdata;
        endcase
        merged = merge_q;
        if (size_q == SZ_BYTE) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        sign_d  = sign_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        res_d   = res_q;
        merge_d = merge_q;
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    port_d  = gnt_port;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    size_d  = sel_size;
                    sign_d  = sel_sign;
                    wdata_d = sel_wdata;
                    err_d   = sel_bad;
                    res_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                // Rejected requests spend this cycle without touching memory so every
                // single-access response lands at the same latency.
                if (err_q) begin
                    state_d = S_RESP;
                end else if (!we_q) begin
                    res_d   = ld_val;
                    state_d = S_RESP;
                end else if (size_q == SZ_WORD) begin
                    state_d = S_RESP;
                end else begin
                    merge_d = mem_rdata;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                rr_d = ~port_q;
                if (port_q) begin
                    hold1_d = res_q;
                end else begin
                    hold0_d = res_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_ena   = 1'b0;
        mem_wena  = 1'b0;
        mem_wdata = '0;
        mem_addr  = addr_q[ADDR_W+1:2];
        p0_done   = 1'b0;
        p1_done   = 1'b0;
        case (state_q)
            S_ACC: begin
                mem_ena = !err_q;
                if (!err_q && we_q && (size_q == SZ_WORD)) begin
                    mem_wena  = 1'b1;
                    mem_wdata = wdata_q;
                end
            end
            S_WR: begin
                mem_ena   = 1'b1;
                mem_wena  = 1'b1;
                mem_wdata = merged;
            end
            S_RESP: begin
                p0_done = !port_q;
                p1_done = port_q;
            end
            default: ;
        endcase
        // A reset cycle abandons the transaction: no strobe, no write, no response.
        if (rst) begin
            mem_ena   = 1'b0;
            mem_wena  = 1'b0;
            mem_wdata = '0;
            mem_addr  = '0;
            p0_done   = 1'b0;
            p1_done   = 1'b0;
        end
    end

    assign p0_err       = p0_done & err_q;
    assign p1_err       = p1_done & err_q;
    assign p0_rdata     = p0_done ? res_q : hold0_q;
    assign p1_rdata     = p1_done ? res_q : hold1_q;
    assign mem_data_bit = 2'b11;
    assign dbg_state    = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
            merge_q <= '0;
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            res_q   <= res_d;
            merge_q <= merge_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed cases, arbitration, reset during a write, and randomized
// traffic checked against a word-array reference model.
module tb_dmem_ctrl;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              p0_req = 0, p0_we = 0, p0_sign = 0;
    logic [31:0]       p0_addr = '0, p0_wdata = '0;
    logic [1:0]        p0_size = '0;
    logic              p1_req = 0, p1_we = 0, p1_sign = 0;
    logic [31:0]       p1_addr = '0, p1_wdata = '0;
    logic [1:0]        p1_size = '0;
    logic              p0_done, p0_err, p1_done, p1_err;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              mem_ena, mem_wena;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [1:0]        mem_data_bit, dbg_state;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic        mem_clear = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          wr_cnt = 0, ena_cnt = 0, wena_bad = 0;
    bit          last_gnt;

    dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size),
        .p0_sign(p0_sign), .p0_wdata(p0_wdata), .p0_done(p0_done), .p0_err(p0_err),
        .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size),
        .p1_sign(p1_sign), .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_err(p1_err),
        .p1_rdata(p1_rdata),
        .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_bit(mem_data_bit), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i) * 32'h9E3779B1;
        end else if (mem_ena && mem_wena) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_ena) ena_cnt <= ena_cnt + 1;
        if (mem_wena) wr_cnt <= wr_cnt + 1;
        if (mem_wena && !mem_ena) wena_bad <= wena_bad + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1);
    end

    function automatic bit ref_err(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'b10) || (s == 2'b01 && a % 2 != 0) || (s == 2'b11 && a % 4 != 0)
            || (a >= 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] s, input bit sg);
        int unsigned nbits, v;
        if (s == 2'b11) return w;
        nbits = (s == 2'b00) ? 8 : 16;
        v = (w >> (8 * (a % 4))) & ((32'd1 << nbits) - 1);
        if (sg && ((v >> (nbits - 1)) != 0)) v = v | ~((32'd1 << nbits) - 1);
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] s, input logic [31:0] d);
        int unsigned m;
        m = (s == 2'b11) ? 32'hFFFF_FFFF : (s == 2'b00) ? 32'hFF : 32'hFFFF;
        m = m << (8 * (a % 4));
        return (w & ~m) | ((d << (8 * (a % 4))) & m);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        p0_req = 0;
        p1_req = 0;
        repeat (2) @(posedge clk);
        #1;
        last_gnt = 1'b1;
    endtask

    task automatic run_op(input bit port, input bit we, input logic [31:0] addr,
                          input logic [1:0] size, input bit sg, input logic [31:0] wd,
                          output int lat, output bit err, output logic [31:0] rd,
                          output int nwr, output int nena, output int spur);
        int wr0, en0;
        wr0 = wr_cnt; en0 = ena_cnt;
        lat = -1; err = 0; rd = '0; spur = 0;
        if (port) begin
            p1_we = we; p1_addr = addr; p1_size = size; p1_sign = sg; p1_wdata = wd; p1_req = 1;
        end else begin
            p0_we = we; p0_addr = addr; p0_size = size; p0_sign = sg; p0_wdata = wd; p0_req = 1;
        end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (port ? p0_done : p1_done) spur++;
            if (port ? p1_done : p0_done) begin
                lat = i;
                err = port ? p1_err : p0_err;
                rd  = port ? p1_rdata : p0_rdata;
                break;
            end
        end
        p0_req = 0;
        p1_req = 0;
        @(posedge clk);
        #1;
        nwr = wr_cnt - wr0;
        nena = ena_cnt - en0;
        if (lat >= 0) last_gnt = port;
    endtask

    task automatic test_reset();
        mem_clear = 1'b1;
        do_reset();
        mem_clear = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i) * 32'h9E3779B1;
        n_tests++;
        if ({p0_done, p0_err, p1_done, p1_err, mem_ena, mem_wena} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {p0_done, p0_err, p1_done, p1_err, mem_ena, mem_wena});
        end
        n_tests++;
        if (p0_rdata !== 0 || p1_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            n_fail++;
            $display("FAIL reset_data: got rd0=%h rd1=%h addr=%h wd=%h want all 0",
                     p0_rdata, p1_rdata, mem_addr, mem_wdata);
        end
        n_tests++;
        if (mem_data_bit !== 2'b11 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_const: got data_bit=%b state=%0d want 11/0", mem_data_bit, dbg_state);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        int lat, nwr, nena, spur;
        bit err;
        logic [31:0] rd;
        run_op(0, 1, 32'h10, 2'b11, 0, 32'hDEADBEEF, lat, err, rd, nwr, nena, spur);
        n_tests++;
        if (lat != 2 || err || nwr != 1 || mem[4] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL sw_word: got lat=%0d err=%0b nwr=%0d mem=%h want 2/0/1/deadbeef",
                     lat, err, nwr, mem[4]);
        end
        run_op(0, 0, 32'h10, 2'b11, 0, 0, lat, err, rd, nwr, nena, spur);
        n_tests++;
        if (lat != 2 || rd !== 32'hDEADBEEF || nwr != 0) begin
            n_fail++;
            $display("FAIL lw_word: got lat=%0d rd=%h nwr=%0d want 2/deadbeef/0", lat, rd, nwr);
        end
        run_op(0, 1, 32'h11, 2'b00, 0, 32'h55, lat, err, rd, nwr, nena, spur);
        n_tests++;
        if (lat != 3 || nwr != 1 || nena != 2 || mem[4] !== 32'hDEAD55EF) begin
            n_fail++;
            $display("FAIL sb_rmw: got lat=%0d nwr=%0d nena=%0d mem=%h want 3/1/2/dead55ef",
                     lat, nwr, nena, mem[4]);
        end
        run_op(0, 0, 32'h13, 2'b00, 1, 0, lat, err, rd, nwr, nena, spur);
        n_tests++;
        if (rd !== 32'hFFFFFFDE) begin
            n_fail++;
            $display("FAIL lb_signed: got %h want ffffffde", rd);
        end
        run_op(0, 0, 32'h13, 2'b00, 0, 0, lat, err, rd, nwr, nena, spur);
        n_tests++;
        if (rd !== 32'h000000DE) begin
            n_fail++;
            $display("FAIL lbu: got %h want 000000de", rd);
        end
        run_op(0, 1, 32'h12, 2'b01, 0, 32'h1234, lat, err, rd, nwr, nena, spur);
        n_tests++;
        if (lat != 3 || mem[4] !== 32'h123455EF) begin
            n_fail++;
            $display("FAIL sh_rmw: got lat=%0d mem=%h want 3/123455ef", lat, mem[4]);
        end
        run_op(0, 0, 32'h11, 2'b01, 1, 0, lat, err, rd, nwr, nena, spur);
        n_tests++;
        if (lat != 2 || !err || nena != 0 || nwr != 0) begin
            n_fail++;
            $display("FAIL lh_misaligned: got lat=%0d err=%0b nena=%0d nwr=%0d want 2/1/0/0",
                     lat, err, nena, nwr);
        end
        run_op(0, 0, 32'h00002000, 2'b11, 0, 0, lat, err, rd, nwr, nena, spur);
        n_tests++;
        if (lat != 2 || !err || nena != 0) begin
            n_fail++;
            $display("FAIL addr_range: got lat=%0d err=%0b nena=%0d want 2/1/0", lat, err, nena);
        end
        run_op(1, 1, 32'h20, 2'b10, 0, 32'hFFFF, lat, err, rd, nwr, nena, spur);
        n_tests++;
        if (lat != 2 || !err || nena != 0 || nwr != 0 || spur != 0) begin
            n_fail++;
            $display("FAIL size_illegal: got lat=%0d err=%0b nena=%0d nwr=%0d spur=%0d want 2/1/0/0/0",
                     lat, err, nena, nwr, spur);
        end
        ref_mem[4] = 32'h123455EF;
    endtask

    task automatic run_pair(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] wd1,
                            output int t0, output int t1, output logic [31:0] rd0);
        p0_we = 0; p0_addr = a0; p0_size = 2'b11; p0_sign = 0; p0_req = 1;
        p1_we = 1; p1_addr = a1; p1_size = 2'b11; p1_wdata = wd1; p1_req = 1;
        t0 = -1; t1 = -1; rd0 = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (p0_done && t0 < 0) begin t0 = i; rd0 = p0_rdata; p0_req = 0; end
            if (p1_done && t1 < 0) begin t1 = i; p1_req = 0; end
            if (t0 >= 0 && t1 >= 0) break;
        end
        p0_req = 0;
        p1_req = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_arbitration();
        int t0, t1, exp0, exp1, lat, nwr, nena, spur;
        bit err;
        logic [31:0] rd, rd0, wd;
        do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int round = 0; round < 2; round++) begin
            if (round == 1) begin
                run_op(0, 0, 32'h10, 2'b11, 0, 0, lat, err, rd, nwr, nena, spur);
            end
            wd = $urandom;
            exp0 = (last_gnt == 1'b1) ? 2 : 5;
            exp1 = (last_gnt == 1'b1) ? 5 : 2;
            run_pair(32'h10, 32'h20, wd, t0, t1, rd0);
            n_tests++;
            if (t0 != exp0 || t1 != exp1) begin
                n_fail++;
                $display("FAIL rr_order_%0d: got p0@%0d p1@%0d want p0@%0d p1@%0d",
                         round, t0, t1, exp0, exp1);
            end
            ref_mem[8] = wd;
            last_gnt = (exp0 > exp1) ? 1'b0 : 1'b1;
            n_tests++;
            if (rd0 !== ref_mem[4] || mem[8] !== wd) begin
                n_fail++;
                $display("FAIL rr_data_%0d: got rd0=%h mem8=%h want %h/%h",
                         round, rd0, mem[8], ref_mem[4], wd);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int dones;
        p0_we = 1; p0_addr = 32'h21; p0_size = 2'b00; p0_sign = 0;
        p0_wdata = {24'h0, ~ref_mem[8][15:8]}; p0_req = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (mem_wena !== 1'b0 || mem_ena !== 1'b0 || p0_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_wr: got wena=%b ena=%b done=%b want 0/0/0", mem_wena, mem_ena, p0_done);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        p0_req = 0;
        last_gnt = 1'b1;
        dones = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (p0_done || p1_done) dones++;
        end
        n_tests++;
        if (dones != 0 || mem[8] !== ref_mem[8]) begin
            n_fail++;
            $display("FAIL rst_abandon: got dones=%0d mem8=%h want 0/%h", dones, mem[8], ref_mem[8]);
        end
    endtask

    task automatic test_random();
        int lat, nwr, nena, spur, exp_lat, exp_ena, r;
        bit err, e, port, we, sg;
        logic [31:0] rd, addr, wd, exp_rd;
        logic [1:0] size;
        int unsigned idx, off;
        for (int n = 0; n < 80; n++) begin
            port = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            sg   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            r    = $urandom_range(0, 9);
            size = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
            idx  = $urandom_range(0, 15);
            off  = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) off = (size == 2'b01) ? (off & 2) : (size == 2'b11) ? 0 : off;
            addr = idx * 4 + off;
            if ($urandom_range(0, 15) == 0) addr = addr | (32'd1 << $urandom_range(13, 31));
            e = ref_err(addr, size);
            exp_lat = (!e && we && size != 2'b11) ? 3 : 2;
            exp_ena = e ? 0 : (we && size != 2'b11) ? 2 : 1;
            if (!e && !we) exp_q.push_back(ref_load(ref_mem[idx], addr, size, sg));
            if (!e && we) ref_mem[idx] = ref_store(ref_mem[idx], addr, size, wd);
            run_op(port, we, addr, size, sg, wd, lat, err, rd, nwr, nena, spur);
            n_tests++;
            if (lat != exp_lat || err != e || nena != exp_ena || nwr != int'(!e && we) || spur != 0) begin
                n_fail++;
                $display("FAIL rand_ctl[%0d]: p%0d we=%0b a=%h sz=%b got lat=%0d err=%0b ena=%0d wr=%0d spur=%0d want %0d/%0b/%0d/%0d/0",
                         n, port, we, addr, size, lat, err, nena, nwr, spur, exp_lat, e, exp_ena, int'(!e && we));
            end
            if (!e && !we && exp_q.size() > 0) begin
                exp_rd = exp_q.pop_front();
                n_tests++;
                if (rd !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rand_load[%0d]: a=%h sz=%b sg=%0b got %h want %h", n, addr, size, sg, rd, exp_rd);
                end
            end
            if (!e) begin
                n_tests++;
                if (mem[idx] !== ref_mem[idx]) begin
                    n_fail++;
                    $display("FAIL rand_mem[%0d]: word %0d got %h want %h", n, idx, mem[idx], ref_mem[idx]);
                end
            end
        end
        n_tests++;
        if (wena_bad != 0) begin
            n_fail++;
            $display("FAIL wena_without_ena: got %0d want 0", wena_bad);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_arbitration();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
